z_event_counter: RTL and testbench

Downstream consumer of the two-bit input sequence detector's `out_z` flag. Counts rising edges of the detector output in a two-digit BCD counter (00–99, wrapping) and drives both digits as BCD and as seven-segment patterns for the board display. Provides a synchronous clear, a hold (freeze) control and a one-cycle overflow pulse on wrap. Same clock domain as the detector; no synchronisers needed.

---
 rtl/z_event_counter_pkg.sv | 9 +
 rtl/z_event_counter_bcd_digit.sv | 17 +
 rtl/z_event_counter.sv | 33 +++
 tb/tb_z_event_counter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/z_event_counter_pkg.sv
// z_event_counter_pkg: BCD limit and seven-segment patterns shared by the counter and its display decode.
package z_event_counter_pkg;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_LUT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  function automatic logic [6:0] seg_decode(input logic [3:0] d, input logic inv);
    return (d <= BCD_MAX ? SEG_LUT[d] : SEG_BLANK) ^ {7{inv}};
  endfunction
endpackage

// File: rtl/z_event_counter_bcd_digit.sv
// bcd_digit: one decade counter stage; an out-of-range value reloads 0 on the next increment.
module bcd_digit
  import z_event_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       co
);
  assign co = en & (q == BCD_MAX);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= q >= BCD_MAX ? 4'd0 : q + 4'd1;
endmodule

// File: rtl/z_event_counter.sv
// z_event_counter: counts rising edges of in_z in a wrapping 00-99 BCD counter with seven-segment outputs.
module z_event_counter
  import z_event_counter_pkg::*;
#(
  parameter logic SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_z,
  input  logic       clr,
  input  logic       hold,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [6:0] seg_ones,
  output logic [6:0] seg_tens,
  output logic       ovf
);
  logic z_d, rise, ones_co, tens_co;
  assign rise = in_z & ~z_d;
  bcd_digit u_ones (.clk, .rst, .clr, .en(rise & ~hold), .q(ones), .co(ones_co));
  bcd_digit u_tens (.clk, .rst, .clr, .en(ones_co), .q(tens), .co(tens_co));
  // z_d tracks in_z even during hold/clr so a level held across either never counts later
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      z_d <= 1'b0;
      ovf <= 1'b0;
    end else begin
      z_d <= in_z;
      ovf <= tens_co & ~clr;
    end
  assign seg_ones = seg_decode(ones, SEG_ACTIVE_LOW);
  assign seg_tens = seg_decode(tens, SEG_ACTIVE_LOW);
endmodule

// File: tb/tb_z_event_counter.sv
// tb_z_event_counter: vector table, directed corner sequences and random stimulus against an integer count model.
module tb_z_event_counter;
  logic clk = 0, rst = 0, in_z = 0, clr = 0, hold = 0;
  logic [3:0] ones, tens, ones_i, tens_i;
  logic [6:0] seg_ones, seg_tens, seg_ones_i, seg_tens_i;
  logic ovf, ovf_i;
  int passed = 0, total = 0;
  int cnt = 0, exp_ovf = 0;
  logic prev_z = 0;
  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  typedef struct {logic z, c, h; int o, t, v;} vec_t;
  vec_t tbl [11];

  z_event_counter dut (.clk, .rst, .in_z, .clr, .hold, .ones, .tens, .seg_ones, .seg_tens, .ovf);
  z_event_counter #(.SEG_ACTIVE_LOW(1'b1)) dut_i (.clk, .rst, .in_z, .clr, .hold, .ones(ones_i), .tens(tens_i),
    .seg_ones(seg_ones_i), .seg_tens(seg_tens_i), .ovf(ovf_i));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  task automatic check_model();
    chk("ones", int'(ones), cnt % 10);
    chk("tens", int'(tens), cnt / 10);
    chk("ovf", int'(ovf), exp_ovf);
    chk("seg_ones", int'(seg_ones), int'(segtab[cnt % 10]));
    chk("seg_tens", int'(seg_tens), int'(segtab[cnt / 10]));
    chk("seg_ones_inv", int'(seg_ones_i), int'(~segtab[cnt % 10] & 7'h7F));
    chk("seg_tens_inv", int'(seg_tens_i), int'(~segtab[cnt / 10] & 7'h7F));
  endtask

  // one clock with the given inputs; model follows clr > hold > rising edge
  task automatic step(input logic z, input logic c, input logic h);
    in_z = z; clr = c; hold = h;
    @(posedge clk);
    if (c) begin cnt = 0; exp_ovf = 0; end
    else if (h) exp_ovf = 0;
    else if (z && !prev_z) begin exp_ovf = (cnt == 99); cnt = (cnt + 1) % 100; end
    else exp_ovf = 0;
    prev_z = z;
    #1;
    check_model();
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin step(1, 0, 0); step(0, 0, 0); end
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 1, 0, 0};
    tbl[1]  = '{1, 0, 0, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 1, 0, 0};
    tbl[3]  = '{1, 0, 0, 2, 0, 0};
    tbl[4]  = '{0, 0, 1, 2, 0, 0};
    tbl[5]  = '{1, 0, 1, 2, 0, 0};
    tbl[6]  = '{1, 0, 0, 2, 0, 0};
    tbl[7]  = '{0, 0, 0, 2, 0, 0};
    tbl[8]  = '{1, 1, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0};
    tbl[10] = '{1, 0, 0, 1, 0, 0};
    repeat (3) @(posedge clk);
    #1;
    check_model();
    @(negedge clk) rst = 1;
    #4;
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].z, tbl[i].c, tbl[i].h);
      chk($sformatf("vec%0d_ones", i), int'(ones), tbl[i].o);
      chk($sformatf("vec%0d_tens", i), int'(tens), tbl[i].t);
      chk($sformatf("vec%0d_ovf", i), int'(ovf), tbl[i].v);
    end
    step(0, 1, 0);
    pulses(12);
    chk("twelve_seg_ones", int'(seg_ones), 'h5B);
    chk("twelve_tens", int'(tens), 1);
    repeat (20) step(1, 0, 0);
    chk("level_once", int'(ones), 3);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("level_again", int'(ones), 4);
    step(0, 1, 0);
    pulses(5);
    for (int i = 0; i < 3; i++) begin step(1, 0, 1); step(0, 0, 1); end
    chk("hold_05", int'(ones), 5);
    step(1, 0, 1);
    step(1, 0, 0);
    chk("hold_release_high", int'(ones), 5);
    step(0, 0, 0);
    step(1, 1, 0);
    chk("clr_rise_ones", int'(ones), 0);
    chk("clr_rise_ovf", int'(ovf), 0);
    step(0, 0, 0);
    pulses(47);
    chk("at47", int'(tens) * 10 + int'(ones), 47);
    @(posedge clk);
    #3 rst = 0;
    #1;
    cnt = 0; exp_ovf = 0; prev_z = 0;
    check_model();
    chk("async_rst_seg", int'(seg_tens_i), 'h40);
    @(negedge clk) rst = 1;
    #4;
    pulses(98);
    chk("at98", int'(tens) * 10 + int'(ones), 98);
    step(1, 0, 0);
    chk("at99_ovf", int'(ovf), 0);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("wrap_ovf", int'(ovf), 1);
    chk("wrap_digits", int'(tens) * 10 + int'(ones), 0);
    step(0, 0, 0);
    chk("wrap_ovf_low", int'(ovf), 0);
    pulses(8);
    chk("inv_seg_ones8", int'(seg_ones_i), 'h00);
    chk("inv_seg_tens0", int'(seg_tens_i), 'h40);
    for (int i = 0; i < 3000; i++)
      step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 199) == 0), logic'($urandom_range(0, 9) == 0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
